key_expand: RTL and testbench

//  AES-128 key schedule engine (FIPS-197 KeyExpansion). Loads a 128-bit cipher key as four
//  32-bit words, then iteratively expands it into 44 words (11 round keys). Stores all words.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/aes_sbox.sv | 14 +
 rtl/key_expand.sv | 155 +++++++++++++++
 tb/tb_key_expand.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES-128 key schedule shared definitions: S-box table, round constants,
// key-expansion FSM states and word/round counts.
package aes_pkg;

    localparam int NUM_WORDS  = 44;
    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        EXPAND = 2'd2,
        DONE   = 2'd3
    } ke_state_t;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup for a single byte.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Plain table lookup; synthesis maps this to LUT logic.
    always_comb begin
        out_byte = SBOX[in_byte];
    end

endmodule

// File: rtl/key_expand.sv
// AES-128 key schedule: loads four key words, expands them to 44 words and
// serves any stored word through a combinational read port.
// Optional build macro KEY_EXPAND_SBOX_PIPE_EN registers the SubWord result,
// so every word with i%4==0 takes two cycles instead of one.
module key_expand
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] cipher_key,
    input  logic [1:0]  r_index,
    input  logic [3:0]  round_key_num,
    output logic [31:0] round_key,
    output logic        done
);

    ke_state_t   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] words_q [0:NUM_WORDS-1];

    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;

    logic [5:0]  prev_idx;
    logic [5:0]  back_idx;
    logic [31:0] prev_word;
    logic [31:0] back_word;
    logic [31:0] rot_word;
    logic [31:0] sub_word;
    logic [31:0] rcon_word;
    logic [5:0]  rd_idx;

`ifdef KEY_EXPAND_SBOX_PIPE_EN
    logic        phase_q, phase_d;
    logic [31:0] sub_q, sub_d;
`endif

    // Neighbour words for the recurrence w[i] = w[i-4] ^ f(w[i-1]).
    always_comb begin
        prev_idx  = cnt_q - 6'd1;
        back_idx  = cnt_q - 6'd4;
        prev_word = words_q[prev_idx];
        back_word = words_q[back_idx];
        rot_word  = {prev_word[23:0], prev_word[31:24]};
        rcon_word = {RCON[cnt_q[5:2]], 24'h0};
    end

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_sbox
            aes_sbox u_sbox (
                .in_byte  (rot_word[8*b +: 8]),
                .out_byte (sub_word[8*b +: 8])
            );
        end
    endgenerate

    // Next-state, counter and register-file write control.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = cnt_q;
        wr_data = cipher_key;
`ifdef KEY_EXPAND_SBOX_PIPE_EN
        phase_d = phase_q;
        sub_d   = sub_q;
`endif
        if (start) begin
            // A start always wins: abort whatever is in flight and reload.
            state_d = LOAD;
            cnt_d   = 6'd0;
`ifdef KEY_EXPAND_SBOX_PIPE_EN
            phase_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: ;
                LOAD: begin
                    wr_en   = 1'b1;
                    wr_data = cipher_key;
                    cnt_d   = cnt_q + 6'd1;
                    if (cnt_q == 6'd3) state_d = EXPAND;
                end
                EXPAND: begin
                    if (cnt_q == 6'(NUM_WORDS)) begin
                        // Extra cycle after w43 so done follows the last write.
                        state_d = DONE;
                    end else if (cnt_q[1:0] != 2'd0) begin
                        wr_en   = 1'b1;
                        wr_data = back_word ^ prev_word;
                        cnt_d   = cnt_q + 6'd1;
                    end else begin
`ifdef KEY_EXPAND_SBOX_PIPE_EN
                        if (!phase_q) begin
                            phase_d = 1'b1;
                            sub_d   = sub_word;
                        end else begin
                            phase_d = 1'b0;
                            wr_en   = 1'b1;
                            wr_data = back_word ^ sub_q ^ rcon_word;
                            cnt_d   = cnt_q + 6'd1;
                        end
`else
                        wr_en   = 1'b1;
                        wr_data = back_word ^ sub_word ^ rcon_word;
                        cnt_d   = cnt_q + 6'd1;
`endif
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
`ifdef KEY_EXPAND_SBOX_PIPE_EN
            phase_q <= 1'b0;
            sub_q   <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef KEY_EXPAND_SBOX_PIPE_EN
            phase_q <= phase_d;
            sub_q   <= sub_d;
`endif
        end
    end

    // Round-key word storage, cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_WORDS; i++) words_q[i] <= 32'h0;
        end else if (wr_en) begin
            words_q[wr_addr] <= wr_data;
        end
    end

    // Read port: {round, column} is exactly 4*round + column.
    always_comb begin
        rd_idx = {round_key_num, r_index};
        if (round_key_num > 4'(NUM_ROUNDS)) round_key = 32'h0;
        else                                round_key = words_q[rd_idx];
        done = (state_q == DONE);
    end

endmodule

// File: tb/tb_key_expand.sv
// Self-checking bench for key_expand: FIPS-197 round keys, done latency,
// rekeying, restart during expansion, async reset and out-of-range reads.
// Build with KEY_EXPAND_SBOX_PIPE_EN to check the registered-SubWord timing.
module tb_key_expand;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] cipher_key;
    logic [1:0]  r_index;
    logic [3:0]  round_key_num;
    logic [31:0] round_key;
    logic        done;

    int tests;
    int fails;

`ifdef KEY_EXPAND_SBOX_PIPE_EN
    localparam int DONE_EDGES = 55;
`else
    localparam int DONE_EDGES = 45;
`endif

    typedef struct {
        int          key_sel;
        logic [3:0]  rkn;
        logic [1:0]  ridx;
        logic [31:0] exp_word;
    } vec_t;

    logic [31:0] keys [0:1][0:3];
    vec_t        vecs [0:19];

    key_expand dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .cipher_key    (cipher_key),
        .r_index       (r_index),
        .round_key_num (round_key_num),
        .round_key     (round_key),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic read_word(input logic [3:0] rkn, input logic [1:0] ridx, output logic [31:0] w);
        round_key_num = rkn;
        r_index       = ridx;
        #1;
        w = round_key;
    endtask

    // Pulse start and feed the four key words, without waiting for done.
    task automatic start_load(input int ks);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_low_after_start", {31'h0, done}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            cipher_key = keys[ks][k];
            tick();
        end
        cipher_key = 32'h0;
    endtask

    // Full load; checks done arrives exactly DONE_EDGES edges after the start edge.
    task automatic load_key(input int ks);
        int n;
        start_load(ks);
        n = 4;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check("done_edges", n, DONE_EDGES);
    endtask

    initial begin
        logic [31:0] w;
        int          loaded;

        tests = 0;
        fails = 0;

        keys[0][0] = 32'h2b7e1516; keys[0][1] = 32'h28aed2a6;
        keys[0][2] = 32'habf71588; keys[0][3] = 32'h09cf4f3c;
        keys[1][0] = 32'h54686174; keys[1][1] = 32'h73206d79;
        keys[1][2] = 32'h204b756e; keys[1][3] = 32'h67204675;

        vecs[0]  = '{0, 4'd0,  2'd0, 32'h2b7e1516};
        vecs[1]  = '{0, 4'd0,  2'd1, 32'h28aed2a6};
        vecs[2]  = '{0, 4'd0,  2'd2, 32'habf71588};
        vecs[3]  = '{0, 4'd0,  2'd3, 32'h09cf4f3c};
        vecs[4]  = '{0, 4'd1,  2'd0, 32'ha0fafe17};
        vecs[5]  = '{0, 4'd1,  2'd1, 32'h88542cb1};
        vecs[6]  = '{0, 4'd1,  2'd2, 32'h23a33939};
        vecs[7]  = '{0, 4'd1,  2'd3, 32'h2a6c7605};
        vecs[8]  = '{0, 4'd10, 2'd0, 32'hd014f9a8};
        vecs[9]  = '{0, 4'd10, 2'd1, 32'hc9ee2589};
        vecs[10] = '{0, 4'd10, 2'd2, 32'he13f0cc8};
        vecs[11] = '{0, 4'd10, 2'd3, 32'hb6630ca6};
        vecs[12] = '{1, 4'd1,  2'd0, 32'he232fcf1};
        vecs[13] = '{1, 4'd1,  2'd1, 32'h91129188};
        vecs[14] = '{1, 4'd1,  2'd2, 32'hb159e4e6};
        vecs[15] = '{1, 4'd1,  2'd3, 32'hd679a293};
        vecs[16] = '{1, 4'd10, 2'd0, 32'h28fddef8};
        vecs[17] = '{1, 4'd10, 2'd1, 32'h6da4244a};
        vecs[18] = '{1, 4'd10, 2'd2, 32'hccc0a4fe};
        vecs[19] = '{1, 4'd10, 2'd3, 32'h3b316f26};

        reset         = 1'b0;
        start         = 1'b0;
        cipher_key    = 32'h0;
        r_index       = 2'd0;
        round_key_num = 4'd0;
        tick();
        tick();

        // Reset state.
        check("reset_done", {31'h0, done}, 32'h0);
        read_word(4'd0, 2'd0, w);  check("reset_w0", w, 32'h0);
        read_word(4'd10, 2'd3, w); check("reset_w43", w, 32'h0);
        reset = 1'b1;
        tick();

        // Table-driven round keys for both FIPS-197 keys.
        loaded = -1;
        for (int v = 0; v < 20; v++) begin
            if (vecs[v].key_sel != loaded) begin
                load_key(vecs[v].key_sel);
                loaded = vecs[v].key_sel;
            end
            read_word(vecs[v].rkn, vecs[v].ridx, w);
            check($sformatf("vec%0d_rk%0d_%0d", v, vecs[v].rkn, vecs[v].ridx), w, vecs[v].exp_word);
        end

        // Out-of-range rounds read as zero while valid keys are stored.
        for (int r = 11; r < 16; r++) begin
            read_word(4'(r), 2'(r), w);
            check($sformatf("oob_round%0d", r), w, 32'h0);
        end

        // Rekey sequence: key A, idle, re-read, key B, key A again.
        load_key(0);
        read_word(4'd10, 2'd3, w); check("rekeyA_r10_3", w, 32'hb6630ca6);
        for (int k = 0; k < 5; k++) tick();
        check("done_held_idle", {31'h0, done}, 32'h1);
        read_word(4'd10, 2'd0, w); check("idle_reread_r10_0", w, 32'hd014f9a8);
        read_word(4'd1, 2'd1, w);  check("idle_reread_r1_1", w, 32'h88542cb1);
        load_key(1);
        read_word(4'd10, 2'd0, w); check("rekeyB_r10_0", w, 32'h28fddef8);
        read_word(4'd0, 2'd2, w);  check("rekeyB_r0_2", w, 32'h204b756e);
        load_key(0);
        read_word(4'd10, 2'd1, w); check("rekeyA2_r10_1", w, 32'hc9ee2589);
        read_word(4'd1, 2'd3, w);  check("rekeyA2_r1_3", w, 32'h2a6c7605);

        // Restart mid-expansion: only the second key survives.
        start_load(0);
        for (int k = 0; k < 12; k++) tick();
        check("done_low_expand", {31'h0, done}, 32'h0);
        load_key(1);
        read_word(4'd1, 2'd0, w);  check("restart_r1_0", w, 32'he232fcf1);
        read_word(4'd10, 2'd3, w); check("restart_r10_3", w, 32'h3b316f26);
        read_word(4'd10, 2'd2, w); check("restart_r10_2", w, 32'hccc0a4fe);

        // Async reset mid-expansion clears done and every stored word at once.
        start_load(0);
        for (int k = 0; k < 15; k++) tick();
        #2;
        reset = 1'b0;
        #1;
        check("areset_done", {31'h0, done}, 32'h0);
        read_word(4'd0, 2'd0, w);  check("areset_w0", w, 32'h0);
        read_word(4'd1, 2'd0, w);  check("areset_w4", w, 32'h0);
        read_word(4'd10, 2'd3, w); check("areset_w43", w, 32'h0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("areset_stays_idle", {31'h0, done}, 32'h0);
        read_word(4'd10, 2'd0, w); check("areset_idle_w40", w, 32'h0);
        load_key(0);
        read_word(4'd10, 2'd0, w); check("after_reset_r10_0", w, 32'hd014f9a8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

endmodule
